bcd_stopwatch_lap: RTL

// Parametrised BCD stopwatch with start/stop, pause, lap-hold and a built-in

---
 rtl/bcd_stopwatch_lap_if.sv | 25 ++
 rtl/bcd_stopwatch_lap.sv | 127 ++++++++++++
 2 files changed

// File: rtl/bcd_stopwatch_lap_if.sv
// Button-pulse inputs and display outputs of the BCD stopwatch, bundled for
// the board-level button conditioning (master) and the stopwatch core (slave).
interface bcd_stopwatch_lap_if #(
    parameter int MIN_DIGITS = 1
);
    logic                    start_stop;
    logic                    lap;
    logic [3:0]              decisecond;
    logic [3:0]              second_r;
    logic [3:0]              second_l;
    logic [4*MIN_DIGITS-1:0] minutes;
    logic                    running;
    logic                    lap_active;
    logic                    wrap;

    modport master (
        output start_stop, lap,
        input  decisecond, second_r, second_l, minutes, running, lap_active, wrap
    );

    modport slave (
        input  start_stop, lap,
        output decisecond, second_r, second_l, minutes, running, lap_active, wrap
    );
endinterface

// File: rtl/bcd_stopwatch_lap.sv
// BCD stopwatch with start/stop, pause, lap hold and a built-in decisecond
// prescaler; the display, running, lap_active and wrap outputs are registered.
//
// state | meaning
// IDLE  | count and prescaler zero, waiting for start_stop
// RUN   | counting, live count displayed
// LAP   | counting, lap latch displayed
// PAUSE | count and prescaler frozen, live count displayed
module bcd_stopwatch_lap #(
    parameter int CLK_DIV    = 10_000_000,
    parameter int MIN_DIGITS = 1
) (
    input  logic               clk,
    input  logic               clr,
    bcd_stopwatch_lap_if.slave sw
);
    localparam int ND = 3 + MIN_DIGITS;
    localparam int CW = 4 * ND;
    localparam int PW = $clog2(CLK_DIV);
    localparam logic [PW-1:0] PSC_MAX = PW'(CLK_DIV - 1);

    typedef enum logic [1:0] {IDLE, RUN, LAP, PAUSE} state_t;

    state_t        state, state_nx;
    logic [PW-1:0] psc, psc_nx;
    logic [CW-1:0] cnt, cnt_nx, cnt_inc;
    logic [CW-1:0] latch, latch_nx;
    logic [CW-1:0] disp_nx, disp_q;
    logic          counting, tick, carry, clear, capture;
    logic          running_nx, lap_active_nx, wrap_nx;
    logic          running_q, lap_active_q, wrap_q;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // start_stop takes priority over lap in every state
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (sw.start_stop) state_nx = RUN;
            RUN:     if (sw.start_stop) state_nx = PAUSE;
                     else if (sw.lap)   state_nx = LAP;
            LAP:     if (sw.start_stop) state_nx = PAUSE;
                     else if (sw.lap)   state_nx = RUN;
            PAUSE:   if (sw.start_stop) state_nx = RUN;
                     else if (sw.lap)   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        counting = (state == RUN) || (state == LAP);
        tick     = counting && (psc == PSC_MAX);
        clear    = (state == PAUSE) && !sw.start_stop && sw.lap;
        capture  = (state == RUN) && !sw.start_stop && sw.lap;

        // ripple increment; carry survives the loop only when every digit was at its limit
        cnt_inc = cnt;
        carry   = 1'b1;
        for (int i = 0; i < ND; i++) begin
            if (carry) begin
                if (cnt[4*i +: 4] == ((i == 2) ? 4'd5 : 4'd9)) begin
                    cnt_inc[4*i +: 4] = 4'd0;
                end else begin
                    cnt_inc[4*i +: 4] = cnt[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end

        psc_nx = psc;
        if (clear || tick) begin
            psc_nx = '0;
        end else if (counting) begin
            psc_nx = psc + PW'(1);
        end

        cnt_nx = cnt;
        if (clear) begin
            cnt_nx = '0;
        end else if (tick) begin
            cnt_nx = cnt_inc;
        end

        latch_nx = capture ? cnt : latch;
    end

    always_comb begin
        disp_nx       = (state_nx == LAP) ? latch_nx : cnt_nx;
        running_nx    = (state_nx == RUN) || (state_nx == LAP);
        lap_active_nx = (state_nx == LAP);
        wrap_nx       = tick && carry;
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            psc          <= '0;
            cnt          <= '0;
            latch        <= '0;
            disp_q       <= '0;
            running_q    <= 1'b0;
            lap_active_q <= 1'b0;
            wrap_q       <= 1'b0;
        end else begin
            psc          <= psc_nx;
            cnt          <= cnt_nx;
            latch        <= latch_nx;
            disp_q       <= disp_nx;
            running_q    <= running_nx;
            lap_active_q <= lap_active_nx;
            wrap_q       <= wrap_nx;
        end
    end

    assign sw.decisecond = disp_q[3:0];
    assign sw.second_r   = disp_q[7:4];
    assign sw.second_l   = disp_q[11:8];
    assign sw.minutes    = disp_q[CW-1:12];
    assign sw.running    = running_q;
    assign sw.lap_active = lap_active_q;
    assign sw.wrap       = wrap_q;
endmodule
